tff_counter: RTL and testbench

TFF_COUNTER -- requirements
Module: tff_counter

---
 rtl/tff_counter.sv | 83 ++++++++
 tb/tb_tff_counter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/tff_counter.sv
// tff_counter: modulo-MODULUS counter built from per-bit toggle logic.
// Optional feature macro: TFF_COUNTER_UPDOWN_EN adds the 'up' port and down counting.
// Without the macro the counter counts up only.
module tff_counter #(
  parameter int unsigned      WIDTH   = 4,
  parameter longint unsigned  MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef TFF_COUNTER_UPDOWN_EN
  input  logic             up,
`endif
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic [WIDTH-1:0] toggled
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  logic             dir_up;
  logic [WIDTH-1:0] term_val;
  logic [WIDTH-1:0] wrap_val;
  logic [WIDTH-1:0] load_sat;
  logic [WIDTH-1:0] tmask;

`ifdef TFF_COUNTER_UPDOWN_EN
  assign dir_up = up;
`else
  assign dir_up = 1'b1;
`endif

  // Terminal value for the current direction and the value the count wraps to.
  assign term_val = dir_up ? MAX_VAL : '0;
  assign wrap_val = dir_up ? '0 : MAX_VAL;

  // Terminal count, zero latency.
  assign tc = en & (q == term_val);

  // Out-of-range load values clamp to the top of the count range.
  assign load_sat = (64'(load_val) >= MODULUS) ? MAX_VAL : load_val;

  // Per-bit toggle enables: a bit flips when every lower bit sits at its
  // terminal level; at the modulus boundary the mask jumps straight to wrap_val.
  always_comb begin
    logic carry;
    tmask = '0;
    carry = en;
    for (int i = 0; i < int'(WIDTH); i++) begin
      tmask[i] = carry;
      carry    = carry & (dir_up ? q[i] : ~q[i]);
    end
    if (tc) begin
      tmask = q ^ wrap_val;
    end
  end

  // Count register with clr > load > en > hold priority.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= '0;
      wrap    <= 1'b0;
      toggled <= '0;
    end else if (clr) begin
      q       <= '0;
      wrap    <= 1'b0;
      toggled <= q;
    end else if (load) begin
      q       <= load_sat;
      wrap    <= 1'b0;
      toggled <= q ^ load_sat;
    end else begin
      q       <= q ^ tmask;
      wrap    <= tc;
      toggled <= tmask;
    end
  end

endmodule

// File: tb/tb_tff_counter.sv
// Bench for tff_counter (WIDTH=4, MODULUS=10): directed literal checks plus
// randomized traffic compared against an arithmetic reference model.
`timescale 1ns/1ps
module tb_tff_counter;

  localparam int MOD = 10;

  logic       clk;
  logic       reset;
  logic       en;
  logic       clr;
  logic       load;
  logic [3:0] load_val;
  logic       up;
  logic       up_eff;
  logic [3:0] q;
  logic       tc;
  logic       wrap;
  logic [3:0] toggled;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  int       m_q    = 0;
  bit       m_wrap = 1'b0;
  logic [3:0] m_tog = '0;

  tff_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
`ifdef TFF_COUNTER_UPDOWN_EN
    .up       (up),
`endif
    .q        (q),
    .tc       (tc),
    .wrap     (wrap),
    .toggled  (toggled)
  );

`ifdef TFF_COUNTER_UPDOWN_EN
  assign up_eff = up;
`else
  assign up_eff = 1'b1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain modular arithmetic on an integer count.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_q    <= 0;
      m_wrap <= 1'b0;
      m_tog  <= '0;
    end else begin
      int nq;
      bit w;
      w = 1'b0;
      if (clr) nq = 0;
      else if (load) nq = (int'(load_val) >= MOD) ? MOD - 1 : int'(load_val);
      else if (en) begin
        if (up_eff) begin
          nq = (m_q + 1) % MOD;
          w  = (m_q == MOD - 1);
        end else begin
          nq = (m_q + MOD - 1) % MOD;
          w  = (m_q == 0);
        end
      end else nq = m_q;
      m_tog  <= 4'(m_q ^ nq);
      m_wrap <= w;
      m_q    <= nq;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("q", int'(q), m_q);
      chk("wrap", int'(wrap), int'(m_wrap));
      chk("toggled", int'(toggled), int'(m_tog));
      chk("tc", int'(tc), int'(en && (m_q == (up_eff ? MOD - 1 : 0))));
    end
  end

  // Apply inputs after a falling edge, then wait until just after the rising edge.
  task automatic step(input bit c, input bit l, input int lv, input bit e, input bit u);
    @(negedge clk);
    #1;
    clr = c; load = l; load_val = 4'(lv); en = e; up = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int seq[12];
    seq = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    reset = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; up = 1'b1;
    #2;
    chk("reset_q", int'(q), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_toggled", int'(toggled), 0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;

    // Free-running count through one wrap.
    for (int k = 0; k < 12; k++) begin
      step(0, 0, 0, 1, 1);
      chk("seq_q", int'(q), seq[k]);
      chk("seq_wrap", int'(wrap), (k == 9) ? 1 : 0);
      chk("seq_tc", int'(tc), (seq[k] == 9) ? 1 : 0);
    end

    // 7 -> 8 flips every bit.
    step(0, 1, 7, 0, 1);
    step(0, 0, 0, 1, 1);
    chk("t78_q", int'(q), 8);
    chk("t78_toggled", int'(toggled), 15);

    // Out-of-range load saturates, load beats en.
    step(0, 1, 13, 1, 1);
    chk("sat_q", int'(q), 9);
    chk("sat_wrap", int'(wrap), 0);

    // clr beats load and en.
    step(0, 1, 5, 0, 1);
    step(1, 1, 3, 1, 1);
    chk("clr_q", int'(q), 0);
    chk("clr_toggled", int'(toggled), 5);

`ifdef TFF_COUNTER_UPDOWN_EN
    // Down count through the 0 -> 9 wrap.
    step(0, 1, 1, 0, 0);
    step(0, 0, 0, 1, 0);
    chk("dn_q0", int'(q), 0);
    chk("dn_tc", int'(tc), 1);
    step(0, 0, 0, 1, 0);
    chk("dn_q9", int'(q), 9);
    chk("dn_wrap", int'(wrap), 1);
    step(0, 0, 0, 1, 0);
    chk("dn_q8", int'(q), 8);
    chk("dn_wrap_end", int'(wrap), 0);
`endif

    // Asynchronous reset between edges.
    step(0, 1, 9, 0, 1);
    step(0, 1, 6, 0, 1);
    chk("pre_rst_toggled", int'(toggled), 15);
    #1 reset = 1'b0;
    #1;
    chk("arst_q", int'(q), 0);
    chk("arst_wrap", int'(wrap), 0);
    chk("arst_toggled", int'(toggled), 0);
    #1 reset = 1'b1;

    // Randomized traffic; the compare process does the checking.
    for (int n = 0; n < 600; n++) begin
      @(negedge clk);
      #1;
      if (!reset) reset = 1'b1;
      else if ($urandom_range(99) < 2) reset = 1'b0;
      clr      = ($urandom_range(99) < 5);
      load     = ($urandom_range(99) < 10);
      load_val = 4'($urandom_range(15));
      en       = ($urandom_range(99) < 75);
`ifdef TFF_COUNTER_UPDOWN_EN
      up       = ($urandom_range(99) < 60);
`endif
    end
    @(negedge clk);
    #1;
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
